// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: stage indices, controller state encoding, NOP.
package riscv_pkg;

  // Pipeline register indices as seen by the stall/bubble vectors
  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IF_ID  = 1;
  localparam int unsigned STG_ID_EX  = 2;
  localparam int unsigned STG_EX_MEM = 3;
  localparam int unsigned STG_WB     = 4;

  // Canonical NOP (addi x0, x0, 0) loaded into a bubbled register
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between a producing load and the ID-stage reads.
// Ports:
//   i_load      producer is a load
//   i_wd        producer destination register
//   i_re1/i_re2 consumer reads rs1/rs2
//   i_rs1/i_rs2 consumer source registers
//   o_hazard    consumer must wait for the load result
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  i_load,
  input  logic [REG_ADDR_W-1:0] i_wd,
  input  logic                  i_re1,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic                  i_re2,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_hazard
);

  // x0 is never a real dependency
  assign o_hazard = i_load && (i_wd != '0) &&
                    ((i_re1 && (i_rs1 == i_wd)) || (i_re2 && (i_rs2 == i_wd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stall requests and load-use
// hazards, applies (or defers) EX redirects, and keeps perf counters plus a
// stall watchdog.
// Ports:
//   clk, rst               clock, async active-low reset
//   stallreq_i             per-stage "not done" requests
//   id_*/ex_load_i/ex_wd_i load-use hazard inputs
//   redirect_i/_pc_i       taken branch/jump from EX
//   perf_clr_i             clear counters and timeout
//   stall_o/bubble_o       hold / NOP-load per pipeline register (same cycle)
//   pc_load_o/pc_o         PC redirect (same cycle)
//   pend_o                 a redirect is waiting on a downstream stall
//   timeout_o              sticky watchdog flag
//   stall_cnt_o/flush_cnt_o performance counters
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_STALL  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic                  id_re1_i,
  input  logic                  id_re2_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  redirect_i,
  input  logic [PC_W-1:0]       redirect_pc_i,
  input  logic                  perf_clr_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] bubble_o,
  output logic                  pc_load_o,
  output logic [PC_W-1:0]       pc_o,
  output logic                  pend_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

  ctrl_state_e             r_state, w_state_nxt;
  logic [PC_W-1:0]         r_pend_pc, w_pend_pc_nxt;
  logic [PC_W-1:0]         w_target;
  logic [NUM_STAGES-1:0]   w_req, w_stall_vec, w_bubble_vec;
  logic                    w_lu, w_blk, w_apply, w_pend, w_any_stall;
  logic [RUN_W-1:0]        r_run;
  logic                    r_timeout;
  logic [CNT_W-1:0]        r_stall_cnt, r_flush_cnt;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .i_load   (ex_load_i),
    .i_wd     (ex_wd_i),
    .i_re1    (id_re1_i),
    .i_rs1    (id_rs1_i),
    .i_re2    (id_re2_i),
    .i_rs2    (id_rs2_i),
    .o_hazard (w_lu)
  );

  // Load-use stalls the IF/ID register alongside any explicit request
  always_comb begin
    w_req            = stallreq_i;
    w_req[STG_IF_ID] = stallreq_i[STG_IF_ID] | w_lu;
  end

  assign w_blk = |w_req[NUM_STAGES-1:STG_ID_EX];

  // Hold everything at or upstream of the highest request; bubble just below it
  always_comb begin
    w_stall_vec  = '0;
    w_bubble_vec = '0;
    w_stall_vec[NUM_STAGES-1] = w_req[NUM_STAGES-1];
    for (int s = NUM_STAGES - 2; s >= 0; s--) begin
      w_stall_vec[s] = w_req[s] | w_stall_vec[s+1];
    end
    for (int s = 1; s < NUM_STAGES; s++) begin
      w_bubble_vec[s] = w_req[s-1] & ~w_stall_vec[s];
    end
  end

  // Redirect FSM: apply at once unless EX or later is stalled, else defer
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_pc_nxt = r_pend_pc;
    w_target      = redirect_pc_i;
    w_apply       = 1'b0;
    w_pend        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (redirect_i) begin
          if (w_blk) begin
            w_state_nxt   = ST_PEND;
            w_pend_pc_nxt = redirect_pc_i;
            w_pend        = 1'b1;
          end else begin
            w_apply = 1'b1;
          end
        end
      end
      ST_PEND: begin
        // EX keeps re-asserting the same redirect while held; use the latched PC
        w_target = r_pend_pc;
        if (w_blk) begin
          w_pend = 1'b1;
        end else begin
          w_apply     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Same-cycle outputs; an applied redirect kills the ID instruction, so its
  // stalls are dropped and IF/ID, ID/EX take NOPs
  always_comb begin
    stall_o   = '0;
    bubble_o  = '0;
    pc_load_o = 1'b0;
    pc_o      = '0;
    pend_o    = 1'b0;
    if (rst) begin
      pend_o = w_pend;
      if (w_apply) begin
        pc_load_o           = 1'b1;
        pc_o                = w_target;
        bubble_o[STG_IF_ID] = 1'b1;
        bubble_o[STG_ID_EX] = 1'b1;
      end else begin
        stall_o  = w_stall_vec;
        bubble_o = w_bubble_vec & ~w_stall_vec;
      end
    end
  end

  assign w_any_stall = |stall_o;

  // FSM state and deferred redirect target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  // Performance counters and stall watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_run       <= '0;
      r_timeout   <= 1'b0;
    end else if (perf_clr_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_run       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_any_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_apply) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_any_stall) begin
        if (r_run != RUN_W'(MAX_STALL)) begin
          r_run <= r_run + RUN_W'(1);
        end
        // This stall cycle is the MAX_STALL-th in a row (or beyond)
        if (r_run >= RUN_W'(MAX_STALL - 1)) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_run <= '0;
      end
    end
  end

  assign timeout_o   = r_timeout;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors, a behavioural model checked every
// cycle on the falling edge, plus literal expectations after each vector.
module tb_pipe_ctrl;

  localparam int unsigned NS = 5;
  localparam int unsigned RA = 5;
  localparam int unsigned PW = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned MS = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stallreq_i;
  logic          id_re1_i, id_re2_i;
  logic [RA-1:0] id_rs1_i, id_rs2_i;
  logic          ex_load_i;
  logic [RA-1:0] ex_wd_i;
  logic          redirect_i;
  logic [PW-1:0] redirect_pc_i;
  logic          perf_clr_i;
  logic [NS-1:0] stall_o, bubble_o;
  logic          pc_load_o;
  logic [PW-1:0] pc_o;
  logic          pend_o, timeout_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  pipe_ctrl #(
    .NUM_STAGES(NS), .REG_ADDR_W(RA), .PC_W(PW), .CNT_W(CW), .MAX_STALL(MS)
  ) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i),
    .id_re1_i(id_re1_i), .id_re2_i(id_re2_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .perf_clr_i(perf_clr_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .pc_load_o(pc_load_o), .pc_o(pc_o),
    .pend_o(pend_o), .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model state: pending redirect, counters, watchdog run length
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;
  int          m_run = 0;
  bit          m_timeout = 1'b0;

  // Per-cycle model check on the falling edge (inputs settled, no clock race)
  always @(negedge clk) begin : cmp
    int          req, k;
    bit          lu, blk, app, epend, eld;
    logic [31:0] es, eb, epc;
    if (!rst) begin
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_bubble", 64'(bubble_o), 64'd0);
      chk("rst_pcload", 64'(pc_load_o), 64'd0);
      chk("rst_pc", 64'(pc_o), 64'd0);
      chk("rst_pend", 64'(pend_o), 64'd0);
      chk("rst_timeout", 64'(timeout_o), 64'd0);
      chk("rst_stallcnt", 64'(stall_cnt_o), 64'd0);
      chk("rst_flushcnt", 64'(flush_cnt_o), 64'd0);
      m_pend = 0; m_pend_pc = '0; m_stall_cnt = '0; m_flush_cnt = '0;
      m_run = 0; m_timeout = 0;
    end else begin
      lu  = ex_load_i && (ex_wd_i != 0) &&
            ((id_re1_i && id_rs1_i == ex_wd_i) || (id_re2_i && id_rs2_i == ex_wd_i));
      req = int'(stallreq_i) | (int'(lu) << 1);
      k = -1;
      for (int i = 0; i < int'(NS); i++) if ((req >> i) & 1) k = i;
      blk = (req >> 2) != 0;
      app = m_pend ? !blk : (redirect_i && !blk);
      if (app) begin
        es = 0; eb = 32'h6; eld = 1; epc = m_pend ? m_pend_pc : redirect_pc_i; epend = 0;
      end else begin
        es    = (k < 0) ? 0 : (32'd1 << (k + 1)) - 1;
        eb    = (k >= 0 && k + 1 < int'(NS)) ? (32'd1 << (k + 1)) : 0;
        eld   = 0; epc = 0;
        epend = m_pend || (redirect_i && blk);
      end
      chk("stall_o", 64'(stall_o), 64'(es));
      chk("bubble_o", 64'(bubble_o), 64'(eb));
      chk("pc_load_o", 64'(pc_load_o), 64'(eld));
      chk("pc_o", 64'(pc_o), 64'(epc));
      chk("pend_o", 64'(pend_o), 64'(epend));
      chk("timeout_o", 64'(timeout_o), 64'(m_timeout));
      chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_stall_cnt));
      chk("flush_cnt_o", 64'(flush_cnt_o), 64'(m_flush_cnt));
      // advance model to the next clock edge
      if (es != 0) begin
        m_stall_cnt++;
        if (m_run < int'(MS)) m_run++;
        if (m_run == int'(MS)) m_timeout = 1;
      end else begin
        m_run = 0;
      end
      if (app) m_flush_cnt++;
      if (perf_clr_i) begin
        m_stall_cnt = 0; m_flush_cnt = 0; m_run = 0; m_timeout = 0;
      end
      if (!m_pend && redirect_i && blk) begin
        m_pend = 1; m_pend_pc = redirect_pc_i;
      end else if (m_pend && !blk) begin
        m_pend = 0;
      end
    end
  end

  // Drive one vector at posedge+1, leave time at posedge+3 for literal checks
  task automatic cyc(input logic [4:0] sr, input logic ld, input logic [4:0] wd,
                     input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                     input logic rd, input logic [31:0] rpc, input logic clr);
    stallreq_i = sr; ex_load_i = ld; ex_wd_i = wd;
    id_re1_i = r1; id_rs1_i = a1; id_re2_i = r2; id_rs2_i = a2;
    redirect_i = rd; redirect_pc_i = rpc; perf_clr_i = clr;
    #2;
  endtask

  task automatic idle();
    cyc(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    // reset state
    idle();
    chk("L_rst_stall", 64'(stall_o), 64'd0);
    chk("L_rst_cnt", 64'(stall_cnt_o), 64'd0);
    nxt();
    rst = 1'b1;
    // idle: nothing asserted, counters stay 0
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("L_idle_stall", 64'(stall_o), 64'd0);
      chk("L_idle_bubble", 64'(bubble_o), 64'd0);
      chk("L_idle_pcload", 64'(pc_load_o), 64'd0);
      nxt();
    end
    idle();
    chk("L_idle_cnt", 64'(stall_cnt_o), 64'd0);
    nxt();
    // load-use on rs1
    cyc(5'd0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 32'd0, 0);
    chk("L_lu_stall", 64'(stall_o), 64'b00011);
    chk("L_lu_bubble", 64'(bubble_o), 64'b00100);
    nxt();
    idle();
    chk("L_lu_cnt", 64'(stall_cnt_o), 64'd1);
    nxt();
    // x0 destination never stalls
    cyc(5'd0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    chk("L_x0_stall", 64'(stall_o), 64'd0);
    nxt();
    // load-use on rs2; rs1 match without read enable does nothing
    cyc(5'd0, 1, 5'd7, 0, 5'd0, 1, 5'd7, 0, 32'd0, 0);
    chk("L_rs2_stall", 64'(stall_o), 64'b00011);
    nxt();
    cyc(5'd0, 1, 5'd9, 0, 5'd9, 0, 5'd0, 0, 32'd0, 0);
    chk("L_nore_stall", 64'(stall_o), 64'd0);
    nxt();
    // immediate redirect
    cyc(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h100, 0);
    chk("L_rd_pcload", 64'(pc_load_o), 64'd1);
    chk("L_rd_pc", 64'(pc_o), 64'h100);
    chk("L_rd_bubble", 64'(bubble_o), 64'b00110);
    nxt();
    idle();
    chk("L_rd_flush", 64'(flush_cnt_o), 64'd1);
    nxt();
    // redirect overrides ID-level stall and load-use
    cyc(5'b00010, 1, 5'd3, 1, 5'd3, 0, 5'd0, 1, 32'h40, 0);
    chk("L_rdlu_stall", 64'(stall_o), 64'd0);
    chk("L_rdlu_bubble", 64'(bubble_o), 64'b00110);
    nxt();
    // stage-specific stall shapes
    cyc(5'b10010, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    chk("L_s4_stall", 64'(stall_o), 64'b11111);
    chk("L_s4_bubble", 64'(bubble_o), 64'd0);
    nxt();
    cyc(5'b00010, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 0);
    chk("L_s1_stall", 64'(stall_o), 64'b00011);
    chk("L_s1_bubble", 64'(bubble_o), 64'b00100);
    nxt();
    // redirect deferred behind EX/MEM stall; later PC re-assertions ignored
    for (int i = 0; i < 3; i++) begin
      cyc(5'b01000, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, (i == 0) ? 32'h200 : 32'h300, 0);
      chk("L_pend_pend", 64'(pend_o), 64'd1);
      chk("L_pend_stall", 64'(stall_o), 64'b01111);
      chk("L_pend_pcload", 64'(pc_load_o), 64'd0);
      nxt();
    end
    idle();
    chk("L_pend_apply", 64'(pc_load_o), 64'd1);
    chk("L_pend_pc", 64'(pc_o), 64'h200);
    chk("L_pend_clr", 64'(pend_o), 64'd0);
    nxt();
    idle();
    chk("L_pend_flush", 64'(flush_cnt_o), 64'd3);
    nxt();
    // watchdog: 15 consecutive ID/EX stalls
    for (int i = 1; i <= 15; i++) begin
      cyc(5'b00100, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 0);
      chk("L_wd_early", 64'(timeout_o), 64'd0);
      nxt();
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("L_wd_sticky", 64'(timeout_o), 64'd1);
      nxt();
    end
    cyc(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0, 1);
    nxt();
    idle();
    chk("L_clr_timeout", 64'(timeout_o), 64'd0);
    chk("L_clr_stallcnt", 64'(stall_cnt_o), 64'd0);
    chk("L_clr_flushcnt", 64'(flush_cnt_o), 64'd0);
    nxt();
    // reset while a redirect is pending
    cyc(5'b01000, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h400, 0);
    chk("L_rp_pend", 64'(pend_o), 64'd1);
    nxt();
    rst = 1'b0;
    cyc(5'b01000, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 32'h400, 0);
    chk("L_rp_stall", 64'(stall_o), 64'd0);
    chk("L_rp_pend0", 64'(pend_o), 64'd0);
    nxt();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("L_rp_nopc", 64'(pc_load_o), 64'd0);
      chk("L_rp_nopend", 64'(pend_o), 64'd0);
      nxt();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
